// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state, register map and field constants for counter_sequencer
package counter_pkg;

  typedef logic [1:0] state_t;

  // FSM states
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Host register addresses
  localparam logic [1:0] ADDR_START    = 2'd0;
  localparam logic [1:0] ADDR_END      = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  // CTRL register fields
  localparam int CTRL_AUTO_RELOAD = 0;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// rtl/counter_sequencer_tick_prescaler.sv - divide-by-(div+1) tick generator with freeze and clear
module tick_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  // A tick is issued in the cycle the count reaches div, unless frozen.
  assign tick = (count == div) && !hold;

  // Count unfrozen cycles, wrapping to zero on each tick; clear wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - host-programmed sequencer driving an external load/enable up-counter
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] reload_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] prescale;
  logic             auto_reload;
  logic             cfg_we;
  logic             terminal;
  logic             tick;

  assign cfg_we   = cfg_valid && cfg_ready;
  assign terminal = (cnt_value == end_val);

  // Prescaler only advances in RUN; it restarts from zero on every load.
  tick_prescaler #(.WIDTH(WIDTH)) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_LOAD),
    .hold  ((state != ST_RUN) || pause),
    .div   (prescale),
    .tick  (tick)
  );

  // Counter controls and status; abort suppresses every strobe in its cycle.
  always_comb begin
    cfg_ready    = (state == ST_IDLE);
    busy         = (state == ST_LOAD) || (state == ST_RUN);
    done         = (state == ST_DONE) && !abort;
    cnt_load     = (state == ST_LOAD) && !abort;
    cnt_en       = (state == ST_RUN) && tick && !terminal && !abort;
    cnt_load_val = start_val;
  end

  // Host register file, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_val   <= '0;
      end_val     <= '0;
      prescale    <= '0;
      auto_reload <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_START:    start_val   <= cfg_data;
        ADDR_END:      end_val     <= cfg_data;
        ADDR_CTRL:     auto_reload <= cfg_data[CTRL_AUTO_RELOAD];
        ADDR_PRESCALE: prescale    <= cfg_data;
        default:       start_val   <= start_val;
      endcase
    end
  end

  // Next-state selection; abort beats start in IDLE and terminal in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!abort && start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (terminal) state_nxt = auto_reload ? ST_LOAD : ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the saturating auto-reload tally, cleared by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      reload_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start && !abort) begin
        reload_cnt <= '0;
      end else if ((state == ST_RUN) && terminal && auto_reload && !abort &&
                   (reload_cnt != {WIDTH{1'b1}})) begin
        reload_cnt <= reload_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - randomized and directed self-checking bench for counter_sequencer
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cnt_value = 8'd0;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic       busy;
  logic       done;
  logic [7:0] reload_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .cnt_value    (cnt_value),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .busy         (busy),
    .done         (done),
    .reload_cnt   (reload_cnt)
  );

  // External counter datapath: load has priority over enable, untouched by rst_n.
  always @(posedge clk) begin
    if (cnt_load)    cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_value + 8'd1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: phase, an unpaused-cycle tally since load and its own counter image.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mphase_t;
  mphase_t m_ph = M_IDLE;
  int m_start = 0, m_end = 0, m_pre = 0, m_auto = 0;
  int m_unp = 0, m_rl = 0, m_cnt = 0;

  always @(negedge clk) begin
    bit e_ready, e_busy, e_done, e_load, e_en, e_tick, e_term;
    if (!rst_n) begin
      m_ph = M_IDLE; m_start = 0; m_end = 0; m_pre = 0; m_auto = 0; m_unp = 0; m_rl = 0;
    end else begin
      e_ready = (m_ph == M_IDLE);
      e_busy  = (m_ph == M_LOAD) || (m_ph == M_RUN);
      e_done  = (m_ph == M_DONE) && !abort;
      e_load  = (m_ph == M_LOAD) && !abort;
      e_tick  = (m_ph == M_RUN) && !pause && ((m_unp % (m_pre + 1)) == m_pre);
      e_term  = (m_cnt == m_end);
      e_en    = e_tick && !e_term && !abort;
      chk("m_cfg_ready", cfg_ready, e_ready);
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      chk("m_cnt_load", cnt_load, e_load);
      chk("m_cnt_en", cnt_en, e_en);
      chk("m_load_val", cnt_load_val, m_start);
      chk("m_reload_cnt", reload_cnt, m_rl);
      chk("m_cnt_value", cnt_value, m_cnt);
      if (e_load)    m_cnt = m_start;
      else if (e_en) m_cnt = (m_cnt + 1) % 256;
      case (m_ph)
        M_IDLE: begin
          if (cfg_valid) begin
            case (cfg_addr)
              2'd0: m_start = cfg_data;
              2'd1: m_end = cfg_data;
              2'd2: m_auto = cfg_data[0];
              default: m_pre = cfg_data;
            endcase
          end
          if (!abort && start) begin m_rl = 0; m_ph = M_LOAD; end
        end
        M_LOAD: begin
          m_unp = 0;
          m_ph = abort ? M_IDLE : M_RUN;
        end
        M_RUN: begin
          if (!pause) m_unp++;
          if (abort) m_ph = M_IDLE;
          else if (e_term) begin
            if (m_auto != 0) begin
              if (m_rl < 255) m_rl++;
              m_ph = M_LOAD;
            end else m_ph = M_DONE;
          end
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Per-cycle records of a directed run; cycle 0 is the cycle start is presented.
  logic [63:0] load_m, en_m, done_m, busy_m;
  int rec_cnt[64];
  int rec_rl[64];

  task automatic run_rec(input int n, input int p_from, input int p_to, input int ab_at);
    load_m = '0; en_m = '0; done_m = '0; busy_m = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      pause = (k >= p_from) && (k <= p_to);
      abort = (k == ab_at);
      @(negedge clk);
      load_m[k] = cnt_load; en_m[k] = cnt_en; done_m[k] = done; busy_m[k] = busy;
      rec_cnt[k] = cnt_value; rec_rl[k] = reload_cnt;
    end
    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    int i;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    if (i == 2000) chk("cfg_write_timeout", 1, 0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_all(input int s, input int e, input int p, input int ar);
    cfg_write(2'd0, 8'(s));
    cfg_write(2'd1, 8'(e));
    cfg_write(2'd3, 8'(p));
    cfg_write(2'd2, 8'(ar));
  endtask

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_reload", reload_cnt, 0);

    // One-shot 3 -> 6, no prescale
    cfg_all(3, 6, 0, 0);
    run_rec(8, -1, -2, -1);
    chk("os_load_cycles", load_m[7:0], 8'h02);
    chk("os_en_cycles", en_m[7:0], 8'h1C);
    chk("os_done_cycles", done_m[7:0], 8'h40);
    chk("os_busy_cycles", busy_m[7:0], 8'h3E);
    for (int k = 2; k <= 5; k++) chk("os_cnt_seq", rec_cnt[k], k + 1);

    // Prescale 2, then the same run with four paused cycles
    cfg_all(0, 2, 2, 0);
    run_rec(12, -1, -2, -1);
    chk("ps_en_cycles", en_m[11:0], 12'h090);
    chk("ps_done_cycles", done_m[11:0], 12'h200);
    run_rec(16, 4, 7, -1);
    chk("pz_en_cycles", en_m[15:0], 16'h0900);
    chk("pz_done_cycles", done_m[15:0], 16'h2000);

    // START == END: terminal on the first RUN cycle
    cfg_all(5, 5, 0, 0);
    run_rec(6, -1, -2, -1);
    chk("eq_en_cycles", en_m[5:0], 0);
    chk("eq_load_cycles", load_m[5:0], 6'h02);
    chk("eq_done_cycles", done_m[5:0], 6'h08);

    // Auto-reload across the wrap, then abort mid-RUN
    cfg_all(254, 1, 0, 1);
    run_rec(21, -1, -2, 18);
    chk("ar_cnt2", rec_cnt[2], 254);
    chk("ar_cnt3", rec_cnt[3], 255);
    chk("ar_cnt4", rec_cnt[4], 0);
    chk("ar_cnt5", rec_cnt[5], 1);
    chk("ar_cnt7", rec_cnt[7], 254);
    chk("ar_load_cycles", load_m[20:0], 21'h10842);
    chk("ar_reload_2", rec_rl[15], 2);
    chk("ar_reload_3", rec_rl[16], 3);
    chk("ar_no_done", done_m[20:0], 0);
    chk("ar_abort_busy", busy_m[18], 1);
    chk("ar_abort_en", en_m[18], 0);
    chk("ar_after_abort_busy", busy_m[19], 0);

    // abort together with start in IDLE
    run_rec(3, -1, -2, 0);
    chk("as_busy", busy_m[2:0], 0);
    chk("as_load", load_m[2:0], 0);
    chk("as_reload_kept", rec_rl[2], 3);

    // Asynchronous reset in the middle of an auto-reload run
    run_rec(13, -1, -2, -1);
    chk("rs_reload_before", rec_rl[12], 2);
    #2;
    chk("rs_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_cnt_en", cnt_en, 0);
    chk("rs_cnt_load", cnt_load, 0);
    chk("rs_done", done, 0);
    chk("rs_cfg_ready", cfg_ready, 1);
    chk("rs_reload", reload_cnt, 0);
    chk("rs_load_val", cnt_load_val, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write held during RUN is accepted on the first IDLE cycle
    cfg_all(0, 3, 9, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd77;
    @(negedge clk);
    chk("hs_ready_run", cfg_ready, 0);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    if (i == 200) chk("hs_idle_timeout", 1, 0);
    chk("hs_val_unchanged", cnt_load_val, 0);
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("hs_val_written", cnt_load_val, 77);

    // Randomized traffic, checked cycle by cycle against the reference
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 63) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = (cfg_addr == 2'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0; abort = 1'b1; cfg_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
